// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory arbiter.
// Imported by the interface, the winner-select sub-module and the top.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 12;
  localparam int MEM_LATENCY_DEF  = 1;
  localparam int STARVE_LIMIT_DEF = 4;

  // Widths sized for the legal maxima (latency 4, starve limit 15).
  localparam int CNT_W    = 3;
  localparam int STARVE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus single-port memory bus for mem_arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_wren;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [31:0]       d_rdata;

  logic              mem_en;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [31:0]       mem_q;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wren, d_addr, d_wdata, mem_q,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    output mem_en, mem_wren, mem_addr, mem_data, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wren, d_addr, d_wdata, mem_q,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    input  mem_en, mem_wren, mem_addr, mem_data, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data has priority unless fetch has been
// starved for STARVE_LIMIT consecutive data grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                o_any,
  output owner_e              o_owner
);

  logic w_starved;

  always_comb begin
    w_starved = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
    o_any     = i_req | d_req;
    o_owner   = OWN_D;
    if (i_req && (!d_req || w_starved)) begin
      o_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port memory, one access
// outstanding at a time, fixed MEM_LATENCY read data return.
//
// state | meaning
// IDLE  | no access in flight; a request is granted combinationally
// WAIT  | access in flight, cnt counts up to MEM_LATENCY then responds
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_nxt;

  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic                r_wren;

  logic                w_pick_any;
  owner_e              w_pick_own;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_mem_en;
  logic                w_mem_wren;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [31:0]         w_mem_data;
  logic                w_done;
  logic                w_i_valid;
  logic                w_d_valid;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_req     (bus.i_req),
    .d_req     (bus.d_req),
    .starve_cnt(r_starve),
    .o_any     (w_pick_any),
    .o_owner   (w_pick_own)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Grant path is gated with rst so every output is 0 while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_starve_nxt = r_starve;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_mem_en     = 1'b0;
    w_mem_wren   = 1'b0;
    w_mem_addr   = '0;
    w_mem_data   = '0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any && !rst) begin
          w_mem_en    = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_W'(1);
          if (w_pick_own == OWN_D) begin
            w_grant_d  = 1'b1;
            w_mem_addr = bus.d_addr[ADDR_W-1:0];
            w_mem_data = bus.d_wdata;
            w_mem_wren = bus.d_wren;
            if (bus.i_req && (r_starve < STARVE_W'(STARVE_LIMIT))) begin
              w_starve_nxt = r_starve + 1'b1;
            end
          end else begin
            w_grant_i    = 1'b1;
            w_mem_addr   = bus.i_addr[ADDR_W-1:0];
            w_starve_nxt = '0;
          end
        end
      end
      WAIT: begin
        w_mem_en   = 1'b1;
        w_mem_addr = r_addr;
        w_mem_data = r_data;
        if (r_cnt == CNT_W'(MEM_LATENCY)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_I;
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
    end else if (w_grant_i || w_grant_d) begin
      r_owner <= w_grant_d ? OWN_D : OWN_I;
      r_addr  <= w_mem_addr;
      r_data  <= w_mem_data;
      r_wren  <= w_mem_wren;
    end
  end

  assign w_i_valid = w_done && (r_owner == OWN_I);
  assign w_d_valid = w_done && (r_owner == OWN_D);

  assign bus.i_gnt    = w_grant_i;
  assign bus.d_gnt    = w_grant_d;
  assign bus.i_valid  = w_i_valid;
  assign bus.d_valid  = w_d_valid;
  // Writes return zero; read data passes straight from the memory port.
  assign bus.i_rdata  = w_i_valid ? bus.mem_q : 32'h0;
  assign bus.d_rdata  = (w_d_valid && !r_wren) ? bus.mem_q : 32'h0;
  assign bus.mem_en   = w_mem_en;
  assign bus.mem_wren = w_mem_wren;
  assign bus.mem_addr = w_mem_addr;
  assign bus.mem_data = w_mem_data;
  assign bus.busy     = (r_state == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1, one at latency 3,
// each with a memory model returning 0xA500_0000 | address.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(12)) b1 ();
  mem_arbiter_if #(.ADDR_W(12)) b3 ();

  mem_arbiter #(.ADDR_W(12), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(b1.slave)
  );

  mem_arbiter #(.ADDR_W(12), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(b3.slave)
  );

  assign b1.mem_q = b1.mem_en ? (32'hA500_0000 | {20'h0, b1.mem_addr}) : 32'h0;
  assign b3.mem_q = b3.mem_en ? (32'hA500_0000 | {20'h0, b3.mem_addr}) : 32'h0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    b1.i_req = 1'b1; b1.i_addr = 32'h0; b1.d_req = 1'b0; b1.d_wren = 1'b0;
    b1.d_addr = 32'h0; b1.d_wdata = 32'h0;
    b3.i_req = 1'b0; b3.i_addr = 32'h0; b3.d_req = 1'b0; b3.d_wren = 1'b0;
    b3.d_addr = 32'h0; b3.d_wdata = 32'h0;

    // Outputs stay 0 during reset even with a request pending
    smp;
    chk("rst_gnt",    {31'h0, b1.i_gnt},  32'h0);
    chk("rst_mem_en", {31'h0, b1.mem_en}, 32'h0);
    chk("rst_busy",   {31'h0, b1.busy},   32'h0);
    chk("rst_valid",  {31'h0, b1.i_valid}, 32'h0);
    chk("rst_addr",   {20'h0, b1.mem_addr}, 32'h0);
    b1.i_req = 1'b0;
    b1.i_addr = 32'h10;
    cyc;
    rst1 = 1'b0;
    rst3 = 1'b0;
    cyc;

    // Fetch read at latency 1, back-to-back request, address truncation
    b1.i_req = 1'b1;
    smp;
    chk("t1_gnt",  {31'h0, b1.i_gnt},    32'h1);
    chk("t1_en",   {31'h0, b1.mem_en},   32'h1);
    chk("t1_addr", {20'h0, b1.mem_addr}, 32'h010);
    chk("t1_wren", {31'h0, b1.mem_wren}, 32'h0);
    chk("t1_busy", {31'h0, b1.busy},     32'h0);
    cyc;
    b1.i_addr = 32'hFFFF_F123;
    smp;
    chk("t1_valid",  {31'h0, b1.i_valid}, 32'h1);
    chk("t1_rdata",  b1.i_rdata,          32'hA500_0010);
    chk("t1_noregnt", {31'h0, b1.i_gnt},  32'h0);
    chk("t1_busy1",  {31'h0, b1.busy},    32'h1);
    chk("t1_dvalid", {31'h0, b1.d_valid}, 32'h0);
    cyc;
    smp;
    chk("t1_gnt2",  {31'h0, b1.i_gnt},    32'h1);
    chk("t1_trunc", {20'h0, b1.mem_addr}, 32'h123);
    cyc;
    b1.i_req = 1'b0;
    smp;
    chk("t1_valid2", {31'h0, b1.i_valid}, 32'h1);
    chk("t1_rdata2", b1.i_rdata,          32'hA500_0123);
    cyc;

    // Starvation: both requesters held high
    b1.d_req  = 1'b1;
    b1.d_wren = 1'b0;
    b1.d_addr = 32'h40;
    b1.i_req  = 1'b1;
    b1.i_addr = 32'h50;
    for (int k = 0; k < 10; k++) begin
      logic got;
      int waited;
      got = 1'b0;
      waited = 0;
      while (!got && waited < 6) begin
        smp;
        if (b1.i_gnt || b1.d_gnt) begin
          got = 1'b1;
          chk($sformatf("t2_order%0d", k), {31'h0, b1.d_gnt}, {31'h0, exp_d[k]});
        end
        cyc;
        waited++;
      end
      if (!got) chk($sformatf("t2_wait%0d", k), {31'h0, got}, 32'h1);
    end
    b1.d_req = 1'b0;
    b1.i_req = 1'b0;
    cyc;
    cyc;

    // Data write at latency 3
    b3.d_req   = 1'b1;
    b3.d_wren  = 1'b1;
    b3.d_addr  = 32'h5;
    b3.d_wdata = 32'hDEAD_BEEF;
    smp;
    chk("t3_gnt",   {31'h0, b3.d_gnt},    32'h1);
    chk("t3_wren",  {31'h0, b3.mem_wren}, 32'h1);
    chk("t3_data",  b3.mem_data,          32'hDEAD_BEEF);
    chk("t3_addr",  {20'h0, b3.mem_addr}, 32'h005);
    chk("t3_busy0", {31'h0, b3.busy},     32'h0);
    cyc;
    b3.d_req  = 1'b0;
    b3.d_wren = 1'b0;
    b3.d_addr = 32'h99;
    smp;
    chk("t3_wren1", {31'h0, b3.mem_wren}, 32'h0);
    chk("t3_busy1", {31'h0, b3.busy},     32'h1);
    chk("t3_val1",  {31'h0, b3.d_valid},  32'h0);
    chk("t3_data1", b3.mem_data,          32'hDEAD_BEEF);
    cyc;
    smp;
    chk("t3_busy2", {31'h0, b3.busy},    32'h1);
    chk("t3_val2",  {31'h0, b3.d_valid}, 32'h0);
    cyc;
    smp;
    chk("t3_val3",   {31'h0, b3.d_valid}, 32'h1);
    chk("t3_rdata3", b3.d_rdata,          32'h0);
    chk("t3_busy3",  {31'h0, b3.busy},    32'h1);
    cyc;
    smp;
    chk("t3_busy4", {31'h0, b3.busy},    32'h0);
    chk("t3_val4",  {31'h0, b3.d_valid}, 32'h0);
    cyc;

    // Data read with d_addr changing while in flight
    b3.d_req  = 1'b1;
    b3.d_addr = 32'h7;
    smp;
    chk("t4_gnt",  {31'h0, b3.d_gnt},    32'h1);
    chk("t4_addr", {20'h0, b3.mem_addr}, 32'h007);
    cyc;
    b3.d_req  = 1'b0;
    b3.d_addr = 32'h99;
    for (int j = 1; j <= 3; j++) begin
      smp;
      chk($sformatf("t4_hold%0d", j), {20'h0, b3.mem_addr}, 32'h007);
      if (j == 3) begin
        chk("t4_val",    {31'h0, b3.d_valid}, 32'h1);
        chk("t4_rdata",  b3.d_rdata,          32'hA500_0007);
        chk("t4_ival",   {31'h0, b3.i_valid}, 32'h0);
        chk("t4_irdata", b3.i_rdata,          32'h0);
      end
      cyc;
    end

    // Reset during WAIT aborts; pending request granted after release
    b3.i_req  = 1'b1;
    b3.i_addr = 32'h20;
    smp;
    chk("t5_gnt", {31'h0, b3.i_gnt}, 32'h1);
    cyc;
    #1;
    rst3 = 1'b1;
    #1;
    chk("t5_rbusy", {31'h0, b3.busy},    32'h0);
    chk("t5_ren",   {31'h0, b3.mem_en},  32'h0);
    chk("t5_rgnt",  {31'h0, b3.i_gnt},   32'h0);
    chk("t5_rval",  {31'h0, b3.i_valid}, 32'h0);
    for (int j = 0; j < 3; j++) begin
      smp;
      chk($sformatf("t5_hval%0d", j), {31'h0, b3.i_valid}, 32'h0);
      chk($sformatf("t5_hgnt%0d", j), {31'h0, b3.i_gnt},   32'h0);
      cyc;
    end
    rst3 = 1'b0;
    smp;
    chk("t5_regnt", {31'h0, b3.i_gnt},    32'h1);
    chk("t5_rbsy",  {31'h0, b3.busy},     32'h0);
    chk("t5_raddr", {20'h0, b3.mem_addr}, 32'h020);
    chk("t5_nval",  {31'h0, b3.i_valid},  32'h0);
    cyc;
    b3.i_req = 1'b0;
    smp;
    chk("t5_busy1", {31'h0, b3.busy},    32'h1);
    chk("t5_val1",  {31'h0, b3.i_valid}, 32'h0);
    cyc;
    cyc;
    smp;
    chk("t5_val3",   {31'h0, b3.i_valid}, 32'h1);
    chk("t5_rdata3", b3.i_rdata,          32'hA500_0020);
    cyc;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
